// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the MEM stage and its alignment helper:
//   - funct3 load encodings and store size encodings
//   - MEM stage handshake state enum
//   - default lane/offset widths and helpers deriving them from XLEN
//   - helpers mapping a load/store code to its access size and signedness
package mem_pkg;

    localparam int DEF_XLEN = 32;
    localparam int BE_W     = DEF_XLEN / 8;
    localparam int OFF_W    = $clog2(BE_W);

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LD  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [2:0] LD_LWU = 3'b110;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;
    localparam logic [1:0] ST_SD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } mem_state_t;

    function automatic int lane_count(input int xlen);
        return xlen / 8;
    endfunction

    function automatic int offset_bits(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    // Access size as log2(bytes). Codes that are not legal for the
    // configured XLEN fall back to the natural width of the datapath.
    function automatic logic [1:0] load_size(input logic [2:0] ltype, input bit is64);
        logic [1:0] natural_sz;
        natural_sz = is64 ? 2'd3 : 2'd2;
        case (ltype)
            LD_LB, LD_LBU: return 2'd0;
            LD_LH, LD_LHU: return 2'd1;
            LD_LW:         return 2'd2;
            LD_LWU:        return is64 ? 2'd2 : natural_sz;
            default:       return natural_sz;
        endcase
    endfunction

    function automatic logic load_signed(input logic [2:0] ltype, input bit is64);
        case (ltype)
            LD_LB, LD_LH: return 1'b1;
            LD_LW:        return is64;
            default:      return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] store_size(input logic [1:0] stype, input bit is64);
        case (stype)
            ST_SB:   return 2'd0;
            ST_SH:   return 2'd1;
            ST_SW:   return 2'd2;
            default: return is64 ? 2'd3 : 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/mem_align_unit.sv
// mem_align_unit
// Purely combinational data alignment for the MEM stage.
// Store side (driven from the op being accepted):
//   acc_off    byte offset of the address inside an XLEN word
//   acc_size   log2 of the access size in bytes
//   st_data    raw store data (rs2)
//   st_be      byte enables for the addressed lanes
//   st_wdata   store data replicated across every lane
//   misaligned address is not a multiple of the access size
// Load side (driven from the latched load and the memory read data):
//   ld_off     latched byte offset
//   ld_type    latched funct3 load type
//   ld_rdata   raw read data from memory
//   ld_data    selected lane, sign/zero extended to XLEN
module mem_align_unit
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] acc_off,
    input  logic [1:0]                acc_size,
    input  logic [XLEN-1:0]           st_data,
    output logic [XLEN/8-1:0]         st_be,
    output logic [XLEN-1:0]           st_wdata,
    output logic                      misaligned,
    input  logic [$clog2(XLEN/8)-1:0] ld_off,
    input  logic [2:0]                ld_type,
    input  logic [XLEN-1:0]           ld_rdata,
    output logic [XLEN-1:0]           ld_data
);

    localparam int LANES = XLEN / 8;
    localparam bit IS64  = (XLEN == 64);

    logic [LANES-1:0] be_base;
    logic [XLEN-1:0]  ld_shifted;
    logic [XLEN-1:0]  ld_keep;
    logic [1:0]       ld_size;
    logic             ld_msb;
    logic             ld_sign;

    // Store path: the enable mask for the size is slid to the offset, and the
    // low bytes of the data are repeated so every lane sees the right byte.
    always_comb begin
        be_base    = '1;
        st_wdata   = st_data;
        misaligned = 1'b0;
        case (acc_size)
            2'd0: begin
                be_base  = LANES'(1);
                st_wdata = {LANES{st_data[7:0]}};
            end
            2'd1: begin
                be_base    = LANES'(3);
                st_wdata   = {(LANES/2){st_data[15:0]}};
                misaligned = acc_off[0];
            end
            2'd2: begin
                be_base    = LANES'(15);
                st_wdata   = {(XLEN/32){st_data[31:0]}};
                misaligned = |acc_off[1:0];
            end
            default: begin
                be_base    = '1;
                st_wdata   = st_data;
                misaligned = |acc_off;
            end
        endcase
        st_be = be_base << acc_off;
    end

    // Load path: shift the addressed lane down to bit 0, keep the access
    // width and fill the upper bits with the lane MSB or zero.
    always_comb begin
        ld_shifted = ld_rdata >> {ld_off, 3'b000};
        ld_size    = load_size(ld_type, IS64);
        case (ld_size)
            2'd0: begin
                ld_keep = XLEN'(8'hFF);
                ld_msb  = ld_shifted[7];
            end
            2'd1: begin
                ld_keep = XLEN'(16'hFFFF);
                ld_msb  = ld_shifted[15];
            end
            2'd2: begin
                ld_keep = XLEN'(32'hFFFF_FFFF);
                ld_msb  = ld_shifted[31];
            end
            default: begin
                ld_keep = '1;
                ld_msb  = ld_shifted[XLEN-1];
            end
        endcase
        ld_sign = load_signed(ld_type, IS64) & ld_msb;
        ld_data = (ld_shifted & ld_keep) | (ld_sign ? ~ld_keep : '0);
    end

endmodule

// File: rtl/mem_stage_hs.sv
// mem_stage_hs
// MEM pipeline stage between EX/MEM and MEM/WB with a req/gnt/rvalid data
// memory handshake. Non-memory ops pass through with one cycle of latency;
// loads and stores hold the pipeline (stall_out) until memory completes.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid, flush     incoming op valid / kill current or incoming op
//   *_mem               EX/MEM fields (address/ALU value, store data, rd,
//                       load/store flags and types, write-enable, memtoreg)
//   stall_out           high whenever an access is in flight
//   dmem_*              data memory request side and response side
//   misaligned_exc      one-cycle pulse for a misaligned access
//   wb_valid + *_wb/out registered MEM/WB results, valid for one cycle
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                flush,
    input  logic [XLEN-1:0]     alu_result_mem,
    input  logic [XLEN-1:0]     rs2_data_mem,
    input  logic [REG_W-1:0]    rd_mem,
    input  logic                mem_read_mem,
    input  logic                mem_write_mem,
    input  logic [2:0]          mem_load_type_mem,
    input  logic [1:0]          mem_store_type_mem,
    input  logic                wb_reg_file_mem,
    input  logic                memtoreg_mem,
    output logic                stall_out,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    output logic [XLEN/8-1:0]   dmem_be,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                misaligned_exc,
    output logic                wb_valid,
    output logic [XLEN-1:0]     alu_result_for_wb,
    output logic [XLEN-1:0]     load_wb_data,
    output logic [REG_W-1:0]    rd_for_wb,
    output logic                wb_reg_file_out,
    output logic                memtoreg_out
);

    localparam int LANES = lane_count(XLEN);
    localparam int OFF_W = offset_bits(XLEN);
    localparam bit IS64  = (XLEN == 64);

    mem_state_t state_q, state_d;

    logic              wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]   alu_wb_q, alu_wb_d;
    logic [XLEN-1:0]   load_wb_q, load_wb_d;
    logic [REG_W-1:0]  rd_wb_q, rd_wb_d;
    logic              wbreg_wb_q, wbreg_wb_d;
    logic              memtoreg_wb_q, memtoreg_wb_d;
    logic              exc_q, exc_d;

    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_we_q, req_we_d;
    logic [LANES-1:0]  req_be_q, req_be_d;
    logic [XLEN-1:0]   req_wdata_q, req_wdata_d;

    logic              op_load_q, op_load_d;
    logic [OFF_W-1:0]  op_off_q, op_off_d;
    logic [2:0]        op_ltype_q, op_ltype_d;
    logic [XLEN-1:0]   op_alu_q, op_alu_d;
    logic [REG_W-1:0]  op_rd_q, op_rd_d;
    logic              op_wbreg_q, op_wbreg_d;
    logic              op_memtoreg_q, op_memtoreg_d;

    logic              accept;
    logic              in_is_mem;
    logic [1:0]        in_size;
    logic [ADDR_W-1:0] addr_full;
    logic [LANES-1:0]  st_be;
    logic [XLEN-1:0]   st_wdata;
    logic              misaligned;
    logic [XLEN-1:0]   ld_data;

    // A read+write op is treated as a load, so mem_read_mem alone picks the side.
    assign accept    = (state_q == S_IDLE) && in_valid && !flush;
    assign in_is_mem = mem_read_mem || mem_write_mem;
    assign in_size   = mem_read_mem ? load_size(mem_load_type_mem, IS64)
                                    : store_size(mem_store_type_mem, IS64);

    generate
        if (ADDR_W <= XLEN) begin : g_addr_trunc
            assign addr_full = alu_result_mem[ADDR_W-1:0];
        end else begin : g_addr_ext
            assign addr_full = {{(ADDR_W-XLEN){1'b0}}, alu_result_mem};
        end
    endgenerate

    mem_align_unit #(
        .XLEN (XLEN)
    ) u_align (
        .acc_off    (alu_result_mem[OFF_W-1:0]),
        .acc_size   (in_size),
        .st_data    (rs2_data_mem),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .misaligned (misaligned),
        .ld_off     (op_off_q),
        .ld_type    (op_ltype_q),
        .ld_rdata   (dmem_rdata),
        .ld_data    (ld_data)
    );

    // Next-state and registered-output logic. Writeback fields only change
    // on a completion, so they hold their last value between pulses.
    always_comb begin
        state_d       = state_q;
        wb_valid_d    = 1'b0;
        exc_d         = 1'b0;
        alu_wb_d      = alu_wb_q;
        load_wb_d     = load_wb_q;
        rd_wb_d       = rd_wb_q;
        wbreg_wb_d    = wbreg_wb_q;
        memtoreg_wb_d = memtoreg_wb_q;
        req_addr_d    = req_addr_q;
        req_we_d      = req_we_q;
        req_be_d      = req_be_q;
        req_wdata_d   = req_wdata_q;
        op_load_d     = op_load_q;
        op_off_d      = op_off_q;
        op_ltype_d    = op_ltype_q;
        op_alu_d      = op_alu_q;
        op_rd_d       = op_rd_q;
        op_wbreg_d    = op_wbreg_q;
        op_memtoreg_d = op_memtoreg_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!in_is_mem || misaligned) begin
                        // Pass-through, or a misaligned access retired
                        // immediately without touching memory.
                        wb_valid_d    = 1'b1;
                        alu_wb_d      = alu_result_mem;
                        rd_wb_d       = rd_mem;
                        memtoreg_wb_d = memtoreg_mem;
                        wbreg_wb_d    = in_is_mem ? 1'b0 : wb_reg_file_mem;
                        exc_d         = in_is_mem;
                    end else begin
                        req_addr_d    = addr_full & ~ADDR_W'(LANES - 1);
                        req_we_d      = !mem_read_mem;
                        req_be_d      = st_be;
                        req_wdata_d   = mem_read_mem ? '0 : st_wdata;
                        op_load_d     = mem_read_mem;
                        op_off_d      = alu_result_mem[OFF_W-1:0];
                        op_ltype_d    = mem_load_type_mem;
                        op_alu_d      = alu_result_mem;
                        op_rd_d       = rd_mem;
                        op_wbreg_d    = wb_reg_file_mem;
                        op_memtoreg_d = memtoreg_mem;
                        state_d       = S_REQ;
                    end
                end
            end

            S_REQ: begin
                if (flush) begin
                    // A granted load still owes a response unless it arrived
                    // in this very cycle; a granted store is simply committed.
                    if (dmem_gnt && op_load_q && !dmem_rvalid) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (dmem_gnt) begin
                    if (!op_load_q || dmem_rvalid) begin
                        wb_valid_d    = 1'b1;
                        alu_wb_d      = op_alu_q;
                        rd_wb_d       = op_rd_q;
                        memtoreg_wb_d = op_memtoreg_q;
                        wbreg_wb_d    = op_load_q ? op_wbreg_q : 1'b0;
                        if (op_load_q) begin
                            load_wb_d = ld_data;
                        end
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (flush) begin
                    state_d = dmem_rvalid ? S_IDLE : S_DRAIN;
                end else if (dmem_rvalid) begin
                    wb_valid_d    = 1'b1;
                    alu_wb_d      = op_alu_q;
                    rd_wb_d       = op_rd_q;
                    memtoreg_wb_d = op_memtoreg_q;
                    wbreg_wb_d    = op_wbreg_q;
                    load_wb_d     = ld_data;
                    state_d       = S_IDLE;
                end
            end

            S_DRAIN: begin
                if (dmem_rvalid) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            wb_valid_q    <= 1'b0;
            exc_q         <= 1'b0;
            alu_wb_q      <= '0;
            load_wb_q     <= '0;
            rd_wb_q       <= '0;
            wbreg_wb_q    <= 1'b0;
            memtoreg_wb_q <= 1'b0;
            req_addr_q    <= '0;
            req_we_q      <= 1'b0;
            req_be_q      <= '0;
            req_wdata_q   <= '0;
            op_load_q     <= 1'b0;
            op_off_q      <= '0;
            op_ltype_q    <= '0;
            op_alu_q      <= '0;
            op_rd_q       <= '0;
            op_wbreg_q    <= 1'b0;
            op_memtoreg_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wb_valid_q    <= wb_valid_d;
            exc_q         <= exc_d;
            alu_wb_q      <= alu_wb_d;
            load_wb_q     <= load_wb_d;
            rd_wb_q       <= rd_wb_d;
            wbreg_wb_q    <= wbreg_wb_d;
            memtoreg_wb_q <= memtoreg_wb_d;
            req_addr_q    <= req_addr_d;
            req_we_q      <= req_we_d;
            req_be_q      <= req_be_d;
            req_wdata_q   <= req_wdata_d;
            op_load_q     <= op_load_d;
            op_off_q      <= op_off_d;
            op_ltype_q    <= op_ltype_d;
            op_alu_q      <= op_alu_d;
            op_rd_q       <= op_rd_d;
            op_wbreg_q    <= op_wbreg_d;
            op_memtoreg_q <= op_memtoreg_d;
        end
    end

    assign stall_out         = (state_q != S_IDLE);
    assign dmem_req          = (state_q == S_REQ);
    assign dmem_we           = req_we_q;
    assign dmem_addr         = req_addr_q;
    assign dmem_be           = req_be_q;
    assign dmem_wdata        = req_wdata_q;
    assign misaligned_exc    = exc_q;
    assign wb_valid          = wb_valid_q;
    assign alu_result_for_wb = alu_wb_q;
    assign load_wb_data      = load_wb_q;
    assign rd_for_wb         = rd_wb_q;
    assign wb_reg_file_out   = wbreg_wb_q;
    assign memtoreg_out      = memtoreg_wb_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs
// Directed and randomized bench for mem_stage_hs (XLEN=32). Inputs are driven
// and outputs sampled on the falling clock edge; expected values come from a
// byte-level model of loads/stores kept in this file.
module tb_mem_stage_hs;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;
    localparam int REG_W  = 5;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              flush;
    logic [XLEN-1:0]   alu_result_mem;
    logic [XLEN-1:0]   rs2_data_mem;
    logic [REG_W-1:0]  rd_mem;
    logic              mem_read_mem;
    logic              mem_write_mem;
    logic [2:0]        mem_load_type_mem;
    logic [1:0]        mem_store_type_mem;
    logic              wb_reg_file_mem;
    logic              memtoreg_mem;
    logic              stall_out;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [XLEN/8-1:0] dmem_be;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [XLEN-1:0]   dmem_rdata;
    logic              misaligned_exc;
    logic              wb_valid;
    logic [XLEN-1:0]   alu_result_for_wb;
    logic [XLEN-1:0]   load_wb_data;
    logic [REG_W-1:0]  rd_for_wb;
    logic              wb_reg_file_out;
    logic              memtoreg_out;

    int checks = 0;
    int errors = 0;

    mem_stage_hs #(
        .XLEN   (XLEN),
        .ADDR_W (ADDR_W),
        .REG_W  (REG_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .in_valid           (in_valid),
        .flush              (flush),
        .alu_result_mem     (alu_result_mem),
        .rs2_data_mem       (rs2_data_mem),
        .rd_mem             (rd_mem),
        .mem_read_mem       (mem_read_mem),
        .mem_write_mem      (mem_write_mem),
        .mem_load_type_mem  (mem_load_type_mem),
        .mem_store_type_mem (mem_store_type_mem),
        .wb_reg_file_mem    (wb_reg_file_mem),
        .memtoreg_mem       (memtoreg_mem),
        .stall_out          (stall_out),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_wdata         (dmem_wdata),
        .dmem_be            (dmem_be),
        .dmem_gnt           (dmem_gnt),
        .dmem_rvalid        (dmem_rvalid),
        .dmem_rdata         (dmem_rdata),
        .misaligned_exc     (misaligned_exc),
        .wb_valid           (wb_valid),
        .alu_result_for_wb  (alu_result_for_wb),
        .load_wb_data       (load_wb_data),
        .rd_for_wb          (rd_for_wb),
        .wb_reg_file_out    (wb_reg_file_out),
        .memtoreg_out       (memtoreg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int accBytes(input bit isLoad, input logic [2:0] lt, input logic [1:0] st);
        if (isLoad) begin
            case (lt)
                3'b000, 3'b100: return 1;
                3'b001, 3'b101: return 2;
                default:        return 4;
            endcase
        end
        case (st)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] lt, input int off, input logic [31:0] word);
        longint v;
        longint span;
        int n;
        n    = accBytes(1'b1, lt, 2'b00);
        v    = longint'(word) >> (8 * off);
        span = longint'(1) << (8 * n);
        v    = v % span;
        if ((lt == 3'b000 || lt == 3'b001) && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [3:0] modelBe(input int n, input int off);
        int v;
        v = ((1 << n) - 1) << off;
        return v[3:0];
    endfunction

    function automatic logic [31:0] modelWdata(input int n, input logic [31:0] data);
        logic [31:0] w;
        w = '0;
        for (int lane = 0; lane < 4; lane++)
            w = w | (((data >> (8 * (lane % n))) & 32'hFF) << (8 * lane));
        return w;
    endfunction

    task automatic clearInputs();
        in_valid           = 1'b0;
        flush              = 1'b0;
        alu_result_mem     = '0;
        rs2_data_mem       = '0;
        rd_mem             = '0;
        mem_read_mem       = 1'b0;
        mem_write_mem      = 1'b0;
        mem_load_type_mem  = '0;
        mem_store_type_mem = '0;
        wb_reg_file_mem    = 1'b0;
        memtoreg_mem       = 1'b0;
        dmem_gnt           = 1'b0;
        dmem_rvalid        = 1'b0;
        dmem_rdata         = '0;
    endtask

    task automatic driveOp(input bit isLoad, input bit isStore, input logic [2:0] lt,
                           input logic [1:0] st, input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rd, input bit wbreg, input bit m2r);
        in_valid           = 1'b1;
        mem_read_mem       = isLoad;
        mem_write_mem      = isStore;
        mem_load_type_mem  = lt;
        mem_store_type_mem = st;
        alu_result_mem     = addr;
        rs2_data_mem       = data;
        rd_mem             = rd;
        wb_reg_file_mem    = wbreg;
        memtoreg_mem       = m2r;
    endtask

    // Runs one op end to end: accept, memory handshake with the given
    // grant/response delays, writeback pulse, and the idle cycle after it.
    task automatic applyStimulus(input string tag, input bit isLoad, input bit isStore,
                                 input logic [2:0] lt, input logic [1:0] st,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] rd, input bit wbreg, input bit m2r,
                                 input int gntDelay, input int rvDelay, input logic [31:0] rdata);
        int n;
        int off;
        n   = accBytes(isLoad, lt, st);
        off = int'(addr[1:0]);
        @(negedge clk);
        checkOutput({tag, ".idle_stall"}, stall_out, 0);
        driveOp(isLoad, isStore, lt, st, addr, data, rd, wbreg, m2r);
        @(negedge clk);
        in_valid = 1'b0;
        if (!isLoad && !isStore) begin
            checkOutput({tag, ".wb_valid"}, wb_valid, 1);
            checkOutput({tag, ".alu"}, alu_result_for_wb, addr);
            checkOutput({tag, ".rd"}, rd_for_wb, rd);
            checkOutput({tag, ".wbreg"}, wb_reg_file_out, wbreg);
            checkOutput({tag, ".m2r"}, memtoreg_out, m2r);
            checkOutput({tag, ".exc"}, misaligned_exc, 0);
            checkOutput({tag, ".stall"}, stall_out, 0);
        end else if (off % n != 0) begin
            checkOutput({tag, ".exc"}, misaligned_exc, 1);
            checkOutput({tag, ".wb_valid"}, wb_valid, 1);
            checkOutput({tag, ".wbreg"}, wb_reg_file_out, 0);
            checkOutput({tag, ".rd"}, rd_for_wb, rd);
            checkOutput({tag, ".req"}, dmem_req, 0);
            checkOutput({tag, ".stall"}, stall_out, 0);
        end else begin
            checkOutput({tag, ".req"}, dmem_req, 1);
            checkOutput({tag, ".stall"}, stall_out, 1);
            checkOutput({tag, ".addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
            checkOutput({tag, ".we"}, dmem_we, !isLoad);
            checkOutput({tag, ".be"}, dmem_be, modelBe(n, off));
            if (!isLoad) checkOutput({tag, ".wdata"}, dmem_wdata, modelWdata(n, data));
            for (int k = 0; k < gntDelay; k++) begin
                @(negedge clk);
                checkOutput({tag, ".req_hold"}, dmem_req, 1);
                checkOutput({tag, ".addr_hold"}, dmem_addr, addr & 32'hFFFF_FFFC);
            end
            dmem_gnt = 1'b1;
            if (isLoad && rvDelay == 0) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = rdata;
            end
            @(negedge clk);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            if (isLoad && rvDelay > 0) begin
                for (int k = 1; k <= rvDelay; k++) begin
                    checkOutput({tag, ".wait_stall"}, stall_out, 1);
                    checkOutput({tag, ".wait_nowb"}, wb_valid, 0);
                    if (k == rvDelay) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata  = rdata;
                    end
                    @(negedge clk);
                end
                dmem_rvalid = 1'b0;
            end
            checkOutput({tag, ".wb_valid"}, wb_valid, 1);
            checkOutput({tag, ".stall_rel"}, stall_out, 0);
            checkOutput({tag, ".wbreg"}, wb_reg_file_out, isLoad ? wbreg : 1'b0);
            checkOutput({tag, ".rd"}, rd_for_wb, rd);
            checkOutput({tag, ".m2r"}, memtoreg_out, m2r);
            checkOutput({tag, ".alu"}, alu_result_for_wb, addr);
            if (isLoad) checkOutput({tag, ".ldata"}, load_wb_data, modelLoad(lt, off, rdata));
        end
        @(negedge clk);
        checkOutput({tag, ".pulse_end"}, wb_valid, 0);
        checkOutput({tag, ".exc_end"}, misaligned_exc, 0);
    endtask

    logic [2:0] ltList [5];

    initial begin
        int kind;
        logic [2:0]  lt;
        logic [1:0]  st;
        logic [31:0] addr;

        ltList = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        clearInputs();
        rst = 1'b0;
        #1;
        checkOutput("reset.stall", stall_out, 0);
        checkOutput("reset.req", dmem_req, 0);
        checkOutput("reset.wb_valid", wb_valid, 0);
        checkOutput("reset.addr", dmem_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases
        applyStimulus("lw_100", 1, 0, 3'b010, 2'b00, 32'h100, 32'h0, 5'd7, 1, 1, 0, 2, 32'hDEADBEEF);
        applyStimulus("lb_103", 1, 0, 3'b000, 2'b00, 32'h103, 32'h0, 5'd8, 1, 1, 1, 1, 32'h80FFFFFF);
        applyStimulus("lbu_103", 1, 0, 3'b100, 2'b00, 32'h103, 32'h0, 5'd9, 1, 1, 0, 0, 32'h80FFFFFF);
        applyStimulus("sh_102", 0, 1, 3'b000, 2'b01, 32'h102, 32'h1234ABCD, 5'd3, 0, 0, 2, 0, 32'h0);
        applyStimulus("lw_101", 1, 0, 3'b010, 2'b00, 32'h101, 32'h0, 5'd4, 1, 1, 0, 0, 32'h0);
        applyStimulus("add", 0, 0, 3'b000, 2'b00, 32'h0000_0042, 32'h0, 5'd5, 1, 0, 0, 0, 32'h0);

        // Op presented together with flush is dropped
        @(negedge clk);
        driveOp(1, 0, 3'b010, 2'b00, 32'h40, 32'h0, 5'd1, 1, 1);
        flush = 1'b1;
        @(negedge clk);
        clearInputs();
        checkOutput("flush_in.req", dmem_req, 0);
        checkOutput("flush_in.stall", stall_out, 0);
        checkOutput("flush_in.wb", wb_valid, 0);

        // Flush in REQ before grant withdraws the request
        driveOp(0, 1, 3'b000, 2'b10, 32'h80, 32'h55, 5'd1, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
        checkOutput("flush_req.req", dmem_req, 1);
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_req.req_gone", dmem_req, 0);
        checkOutput("flush_req.stall", stall_out, 0);
        checkOutput("flush_req.wb", wb_valid, 0);

        // Flush while a load waits for data: drain the late response
        driveOp(1, 0, 3'b010, 2'b00, 32'h200, 32'h0, 5'd6, 1, 1);
        @(negedge clk);
        in_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        flush    = 1'b1;
        checkOutput("flush_wait.stall", stall_out, 1);
        @(negedge clk);
        flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checkOutput("flush_wait.drain_stall", stall_out, 1);
            checkOutput("flush_wait.drain_nowb", wb_valid, 0);
            @(negedge clk);
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_2222;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        checkOutput("flush_wait.released", stall_out, 0);
        checkOutput("flush_wait.nowb", wb_valid, 0);
        applyStimulus("add_after_flush", 0, 0, 3'b000, 2'b00, 32'h0000_1234, 32'h0, 5'd12, 1, 1, 0, 0, 32'h0);

        // Asynchronous reset in the middle of WAIT
        @(negedge clk);
        driveOp(1, 0, 3'b010, 2'b00, 32'h300, 32'h0, 5'd9, 1, 1);
        @(negedge clk);
        in_valid = 1'b0;
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        checkOutput("rst_wait.stall", stall_out, 1);
        #1 rst = 1'b0;
        #1;
        checkOutput("rst_wait.stall0", stall_out, 0);
        checkOutput("rst_wait.req0", dmem_req, 0);
        checkOutput("rst_wait.addr0", dmem_addr, 0);
        checkOutput("rst_wait.be0", dmem_be, 0);
        checkOutput("rst_wait.ldata0", load_wb_data, 0);
        checkOutput("rst_wait.alu0", alu_result_for_wb, 0);
        checkOutput("rst_wait.rd0", rd_for_wb, 0);
        checkOutput("rst_wait.wbreg0", wb_reg_file_out, 0);
        checkOutput("rst_wait.m2r0", memtoreg_out, 0);
        @(negedge clk);
        rst         = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        checkOutput("rst_wait.late_rvalid_wb", wb_valid, 0);
        checkOutput("rst_wait.late_rvalid_stall", stall_out, 0);
        checkOutput("rst_wait.late_rvalid_ldata", load_wb_data, 0);

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            lt   = ltList[$urandom_range(0, 4)];
            st   = 2'($urandom_range(0, 2));
            addr = $urandom & 32'h0000_FFFF;
            applyStimulus($sformatf("rnd%0d", i), kind == 1, kind == 2, lt, st, addr,
                          $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
